// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the interface-facing top and the byte packer.
package imem_boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ERROR
  } state_e;

  localparam int LANES = 4;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;

  // Drop byte b into byte lane `lane` of word w.
  function automatic logic [31:0] lane_insert(
    logic [31:0] w,
    logic [1:0]  lane,
    logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, imem write port and core-control signals of the loader.
// master = byte source / core side, slave = loader.
interface imem_boot_loader_if #(
  parameter int IDX_W = 8
);

  logic             loadReq;
  logic [IDX_W:0]   wordCount;
  logic             byteValid;
  logic [7:0]       byteData;
  logic             byteReady;
  logic             imemWrEn;
  logic [31:0]      imemWrAddr;
  logic [31:0]      imemWrData;
  logic             tbStart;
  logic [31:0]      initInstAddr;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output loadReq,
    output wordCount,
    output byteValid,
    output byteData,
    input  byteReady,
    input  imemWrEn,
    input  imemWrAddr,
    input  imemWrData,
    input  tbStart,
    input  initInstAddr,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  loadReq,
    input  wordCount,
    input  byteValid,
    input  byteData,
    output byteReady,
    output imemWrEn,
    output imemWrAddr,
    output imemWrData,
    output tbStart,
    output initInstAddr,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Little-endian byte-to-word packer: lane counter plus partial word.
// word/word_done are combinational so the 4th byte needs no bubble.
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;

  // Insert the incoming byte and advance the lane, wrapping 3->0.
  always_comb begin
    lane_d    = lane_q;
    acc_d     = acc_q;
    word      = lane_insert(acc_q, lane_q, byte_in);
    word_done = accept && (lane_q == 2'(LANES - 1));
    if (clear) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (accept) begin
      lane_d = lane_q + 2'd1;
      acc_d  = word_done ? '0 : word;
    end
  end

  // Lane and partial-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte stream into imem as words, then starts the core.
// Optional checksum phase and ERROR state: define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          IDX_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1 << IDX_W);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             run_q, run_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
  logic             chk_q, chk_d;
`endif

  logic             start;
  logic             emit;
  logic             accept;
  logic             last_word;
  logic             word_done;
  logic [31:0]      pk_word;
  logic [CW-1:0]    wc_sat;

  assign accept    = bus.byteValid && bus.byteReady;
  assign wc_sat    = (bus.wordCount > MAX_WORDS) ?
                     MAX_WORDS : bus.wordCount;
  assign last_word = ({1'b0, idx_q} == cnt_q - CW'(1));

  imem_boot_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .accept    (accept),
    .byte_in   (bus.byteData),
    .word      (pk_word),
    .word_done (word_done)
  );

  // Next state, write port and run-enable; a taken loadReq always
  // drops tbStart for at least one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start     = 1'b0;
    emit      = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d     = sum_q;
    chk_d     = chk_q;
`endif
    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (bus.loadReq) begin
          start = 1'b1;
          cnt_d = wc_sat;
          idx_d = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_d   = '0;
          chk_d   = (wc_sat == '0);
          state_d = LOAD;
`else
          state_d = (wc_sat == '0) ? RUN : LOAD;
`endif
        end
      end
      LOAD: begin
        if (word_done) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          if (chk_q) begin
            state_d = (pk_word == sum_q) ? RUN : ERROR;
          end else begin
            emit = 1'b1;
          end
`else
          emit = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = BASE_ADDR + 32'({idx_q, 2'b00});
      wr_data_d = pk_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_d     = sum_q + pk_word;
`endif
      if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        chk_d   = 1'b1;
`else
        state_d = RUN;
`endif
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    run_d = (state_q == RUN) && (state_d == RUN) && !start;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      run_q     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= '0;
      chk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      run_q     <= run_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_q     <= sum_d;
      chk_q     <= chk_d;
`endif
    end
  end

  assign bus.byteReady    = (state_q == LOAD);
  assign bus.busy         = (state_q == LOAD);
  assign bus.imemWrEn     = wr_en_q;
  assign bus.imemWrAddr   = wr_addr_q;
  assign bus.imemWrData   = wr_data_q;
  assign bus.tbStart      = run_q;
  assign bus.done         = run_q;
  assign bus.initInstAddr = BASE_ADDR;
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign bus.error        = (state_q == ERROR);
`else
  assign bus.error        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0 and 0x100) share
// one stimulus stream and are checked against a word-level model.
module tb_imem_boot_loader;

  localparam int IDX_W = 8;
  localparam int CW    = IDX_W + 1;
  localparam int MAXW  = 1 << IDX_W;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam int CHK_BYTES = 4;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          load_req   = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data  = '0;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.IDX_W(IDX_W)) bus_a ();
  imem_boot_loader_if #(.IDX_W(IDX_W)) bus_b ();

  assign bus_a.loadReq   = load_req;
  assign bus_a.wordCount = word_count;
  assign bus_a.byteValid = byte_valid;
  assign bus_a.byteData  = byte_data;
  assign bus_b.loadReq   = load_req;
  assign bus_b.wordCount = word_count;
  assign bus_b.byteValid = byte_valid;
  assign bus_b.byteData  = byte_data;

  imem_boot_loader #(.BASE_ADDR(BASE_A), .IDX_W(IDX_W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  imem_boot_loader #(.BASE_ADDR(BASE_B), .IDX_W(IDX_W)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // {wrEn, byteReady, busy, tbStart, done, error}
  logic [5:0]  flags     [2];
  logic [31:0] wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic [31:0] init_addr [2];

  assign flags[0] = {bus_a.imemWrEn, bus_a.byteReady, bus_a.busy,
                     bus_a.tbStart, bus_a.done, bus_a.error};
  assign flags[1] = {bus_b.imemWrEn, bus_b.byteReady, bus_b.busy,
                     bus_b.tbStart, bus_b.done, bus_b.error};
  assign wr_addr[0]   = bus_a.imemWrAddr;
  assign wr_addr[1]   = bus_b.imemWrAddr;
  assign wr_data[0]   = bus_a.imemWrData;
  assign wr_data[1]   = bus_b.imemWrData;
  assign init_addr[0] = bus_a.initInstAddr;
  assign init_addr[1] = bus_b.initInstAddr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model, tracked in words and byte counts.
  logic [31:0] prog [$];
  int          m_n, m_total, m_nacc, m_k;
  bit          m_ld, m_run, m_err, m_wr, m_tbs;
  logic [31:0] m_chk = '0;
  int          n_wr      [2];
  logic [31:0] last_addr [2];

  typedef struct {
    logic [CW-1:0] wc;
    int            gap;
    logic [31:0]   w0, w1, w2, w3;
    int            exp_writes;
    logic [31:0]   exp_last_off;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h, expected %h",
               name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE_A : BASE_B;
  endfunction

  function automatic int sat_n(input logic [CW-1:0] wc);
    return (int'(wc) > MAXW) ? MAXW : int'(wc);
  endfunction

  function automatic logic [31:0] prog_sum();
    logic [31:0] s;
    s = '0;
    foreach (prog[i]) s = s + prog[i];
    return s;
  endfunction

  // Advance one clock: update the model for this edge, then compare.
  task automatic tick(output bit acc);
    bit run_pre;
    bit taken;
    run_pre = m_run;
    taken   = 1'b0;
    acc     = 1'b0;
    m_wr    = 1'b0;
    if (rst) begin
      m_ld   = 1'b0;
      m_run  = 1'b0;
      m_err  = 1'b0;
      m_nacc = 0;
    end else if (m_ld) begin
      if (byte_valid) begin
        acc = 1'b1;
        m_nacc++;
        if (m_nacc % 4 == 0 && m_nacc / 4 <= m_n) begin
          m_wr = 1'b1;
          m_k  = m_nacc / 4 - 1;
        end
        if (m_nacc == m_total) begin
          m_ld = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          m_err = (m_chk != prog_sum());
          m_run = !m_err;
`else
          m_run = 1'b1;
`endif
        end
      end
    end else if (load_req) begin
      taken   = 1'b1;
      m_n     = sat_n(word_count);
      m_total = 4 * m_n + CHK_BYTES;
      m_nacc  = 0;
      m_err   = 1'b0;
      m_ld    = (m_total > 0);
      m_run   = !m_ld;
    end
    m_tbs = run_pre && m_run && !taken;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("flags%0d", d), 32'(flags[d]),
            32'({m_wr, m_ld, m_ld, m_tbs, m_tbs, m_err}));
      if (m_wr && flags[d][5]) begin
        check($sformatf("wr_addr%0d", d), wr_addr[d],
              base_of(d) + 32'(4 * m_k));
        check($sformatf("wr_data%0d", d), wr_data[d], prog[m_k]);
      end
      if (flags[d][5]) begin
        n_wr[d]++;
        last_addr[d] = wr_addr[d];
      end
    end
  endtask

  // Request a load of prog[] and stream its bytes with a gap pattern.
  task automatic run_load(input logic [CW-1:0] wc, input int gap,
                          input bit bad_chk);
    logic [7:0]  tx [$];
    logic [31:0] w;
    bit          acc;
    int          budget;
    n_wr[0] = 0;
    n_wr[1] = 0;
    foreach (prog[i]) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) tx.push_back(w[8*b +: 8]);
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    m_chk = prog_sum() + (bad_chk ? 32'd1 : 32'd0);
    for (int b = 0; b < 4; b++) tx.push_back(m_chk[8*b +: 8]);
`else
    m_chk = bad_chk ? 32'd1 : 32'd0;
`endif
    load_req   = 1'b1;
    word_count = wc;
    byte_valid = 1'b0;
    tick(acc);
    load_req   = 1'b0;
    word_count = CW'($urandom);
    budget     = 8 * tx.size() + 20;
    while (tx.size() > 0 && budget > 0) begin
      case (gap)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (cyc % 2 == 0);
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = byte_valid ? tx[0] : 8'($urandom);
      load_req  = (gap == 2) && ($urandom_range(0, 7) == 0);
      tick(acc);
      if (acc) void'(tx.pop_front());
      budget--;
    end
    check("byte_drain", 32'(tx.size()), 32'd0);
    load_req = 1'b0;
    repeat (3) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_data  = 8'($urandom);
      tick(acc);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    m_ld  = 1'b0;
    m_run = 1'b0;
    m_err = 1'b0;
    m_n   = 0;
    m_nacc = 0;
    m_k   = 0;

    vecs[0] = '{9'd3, 0, 32'h52324082, 32'h4433C102, 32'h4221C182,
                32'h0, 3, 32'h8};
    vecs[1] = '{9'd3, 1, 32'h52324082, 32'h4433C102, 32'h4221C182,
                32'h0, 3, 32'h8};
    vecs[2] = '{9'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0};
    vecs[3] = '{9'd1, 0, 32'h00000013, 32'h0, 32'h0, 32'h0, 1, 32'h0};
    vecs[4] = '{9'd4, 2, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF,
                32'h80000001, 4, 32'hC};
    vecs[5] = '{9'd2, 1, 32'h00C00113, 32'h01000093, 32'h0, 32'h0,
                2, 32'h4};

    // Reset values.
    rst = 1'b1;
    tick(acc);
    tick(acc);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_flags%0d", d), 32'(flags[d]), 32'd0);
      check($sformatf("rst_addr%0d", d), wr_addr[d], base_of(d));
      check($sformatf("rst_data%0d", d), wr_data[d], 32'd0);
      check($sformatf("init_addr%0d", d), init_addr[d], base_of(d));
    end
    rst = 1'b0;
    tick(acc);

    // Directed table.
    foreach (vecs[i]) begin
      prog.delete();
      if (vecs[i].exp_writes > 0) prog.push_back(vecs[i].w0);
      if (vecs[i].exp_writes > 1) prog.push_back(vecs[i].w1);
      if (vecs[i].exp_writes > 2) prog.push_back(vecs[i].w2);
      if (vecs[i].exp_writes > 3) prog.push_back(vecs[i].w3);
      run_load(vecs[i].wc, vecs[i].gap, 1'b0);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("v%0d_nwr%0d", i, d), 32'(n_wr[d]),
              32'(vecs[i].exp_writes));
        if (vecs[i].exp_writes > 0)
          check($sformatf("v%0d_last%0d", i, d), last_addr[d],
                base_of(d) + vecs[i].exp_last_off);
        check($sformatf("v%0d_start%0d", i, d), 32'(flags[d][2]), 32'd1);
      end
    end

`ifndef IMEM_BOOT_CHECKSUM_EN
    // Zero-count reload from RUN: tbStart drops, back two cycles later.
    load_req   = 1'b1;
    word_count = '0;
    tick(acc);
    load_req   = 1'b0;
    check("zero_drop", 32'(flags[0][2]), 32'd0);
    tick(acc);
    check("zero_rise", 32'(flags[0][2]), 32'd1);
    check("zero_nowr", 32'(flags[0][5]), 32'd0);
`endif

    // Reset after 6 of 12 bytes, then a clean load.
    prog.delete();
    prog.push_back(32'h52324082);
    prog.push_back(32'h4433C102);
    prog.push_back(32'h4221C182);
    load_req   = 1'b1;
    word_count = 9'd3;
    tick(acc);
    load_req   = 1'b0;
    for (int j = 0; j < 20 && m_nacc < 6; j++) begin
      byte_valid = 1'b1;
      byte_data  = prog[m_nacc / 4][8*(m_nacc % 4) +: 8];
      tick(acc);
    end
    rst        = 1'b1;
    load_req   = 1'b1;
    byte_valid = 1'b1;
    tick(acc);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid_rst_flags%0d", d), 32'(flags[d]), 32'd0);
      check($sformatf("mid_rst_addr%0d", d), wr_addr[d], base_of(d));
      check($sformatf("mid_rst_data%0d", d), wr_data[d], 32'd0);
    end
    rst        = 1'b0;
    load_req   = 1'b0;
    byte_valid = 1'b0;
    tick(acc);
    run_load(9'd3, 0, 1'b0);
    check("post_rst_nwr_b", 32'(n_wr[1]), 32'd3);
    check("post_rst_last_b", last_addr[1], 32'h108);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Wrong checksum parks in ERROR; a new load recovers.
    run_load(9'd3, 0, 1'b1);
    check("chk_err", 32'(flags[0][0]), 32'd1);
    check("chk_err_start", 32'(flags[0][2]), 32'd0);
    run_load(9'd3, 1, 1'b0);
    check("chk_ok_start", 32'(flags[0][2]), 32'd1);
    check("chk_ok_err", 32'(flags[0][0]), 32'd0);
`endif

    // Oversized count saturates to 2^IDX_W words.
    prog.delete();
    for (int j = 0; j < MAXW; j++) prog.push_back($urandom);
    run_load('1, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("sat_nwr%0d", d), 32'(n_wr[d]), 32'(MAXW));
      check($sformatf("sat_last%0d", d), last_addr[d],
            base_of(d) + 32'(4 * (MAXW - 1)));
    end

    // Random programs with random source gaps.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 6);
      prog.delete();
      for (int j = 0; j < n; j++) prog.push_back($urandom);
      run_load(CW'(n), 2, 1'b0);
      check($sformatf("rnd%0d_nwr", r), 32'(n_wr[0]), 32'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
